jpeg_bitpack: RTL

- Final stage of the JPEG entropy path: sits between the Huffman coder and the memory-writing DMA controller.
- Packs variable-length codes, MSB first, into a byte stream and inserts JPEG marker stuffing (0x00 after every 0xFF).
- Assembles bytes into 16-bit little-endian words and hands them off under the controller's rdy_in/ena_out handshake.
- On a flush request, pads the stream to a byte boundary with 1-bits, drains all data and pulses done_flush.

---
 rtl/jpeg_pkg.sv | 7 +
 rtl/jpeg_bitpack_if.sv | 13 +
 rtl/jpeg_byte_stuffer.sv | 26 ++
 rtl/jpeg_bitpack.sv | 100 ++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared constants and types for the JPEG entropy-path bit packer.
package jpeg_pkg;
  localparam int JPEG_MAX_LEN = 16;
  localparam logic [7:0] JPEG_STUFF_BYTE = 8'hFF;
  localparam logic JPEG_PAD_BIT = 1'b1;
  typedef enum logic [2:0] {RUN, PAD, DRAIN, LAST, DONE} bitpack_state_t;
endpackage

// File: rtl/jpeg_bitpack_if.sv
// jpeg_bitpack_if: code input, flush control and word output of the bit packer.
interface jpeg_bitpack_if #(parameter int MAX_LEN = jpeg_pkg::JPEG_MAX_LEN);
  logic [MAX_LEN-1:0] in_code;
  logic [4:0] in_len;
  logic in_valid, in_ready, flush, rdy_in;
  logic [15:0] out_bits;
  logic [1:0] out_valid;
  logic ena_out, done_flush;
  modport master (output in_code, in_len, in_valid, flush, rdy_in,
                  input in_ready, out_bits, out_valid, ena_out, done_flush);
  modport slave (input in_code, in_len, in_valid, flush, rdy_in,
                 output in_ready, out_bits, out_valid, ena_out, done_flush);
endinterface

// File: rtl/jpeg_byte_stuffer.sv
// jpeg_byte_stuffer: one-byte stage that inserts 0x00 after every 0xFF.
module jpeg_byte_stuffer import jpeg_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  input  logic       out_ready
);
  // A forwarded 0xFF turns into a held 0x00, so the slot stays busy one more cycle
  assign in_ready = !out_valid || (out_ready && out_byte != JPEG_STUFF_BYTE);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_byte <= 8'h00;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_byte <= in_byte;
    end else if (out_valid && out_ready) begin
      out_valid <= out_byte == JPEG_STUFF_BYTE;
      out_byte <= 8'h00;
    end
  end
endmodule

// File: rtl/jpeg_bitpack.sv
// jpeg_bitpack: packs Huffman codes MSB-first into stuffed bytes and 16-bit LE words.
module jpeg_bitpack import jpeg_pkg::*; #(
  parameter int MAX_LEN = JPEG_MAX_LEN,
  parameter int ACC_W = 32
) (
  input logic clk,
  input logic rst,
  jpeg_bitpack_if.slave bp
);
  localparam int CW = $clog2(ACC_W + 1);
  localparam int SW = CW + 1;
  bitpack_state_t state;
  logic [ACC_W-1:0] acc, acc_sh, code_ext;
  logic [CW-1:0] cnt, cnt_sh;
  logic [SW-1:0] shamt;
  logic [MAX_LEN-1:0] mask;
  logic [7:0] lo, s_out_byte;
  logic lo_valid, word_pending, s_in_ready, s_out_valid, extract, accept, asm_ready, asm_take;
  always_comb begin
    extract = cnt >= CW'(8) && s_in_ready;
    accept = bp.in_valid && bp.in_ready;
    acc_sh = extract ? acc << 8 : acc;
    cnt_sh = extract ? cnt - CW'(8) : cnt;
    mask = ~({MAX_LEN{1'b1}} << bp.in_len);
    shamt = SW'(ACC_W) - SW'(cnt_sh) - SW'(bp.in_len);
    code_ext = ACC_W'(bp.in_code & mask) << shamt;
    asm_ready = !word_pending || bp.ena_out;
    asm_take = s_out_valid && asm_ready;
  end
  assign bp.in_ready = state == RUN && cnt <= CW'(ACC_W - MAX_LEN);
  assign bp.ena_out = word_pending && bp.rdy_in;
  jpeg_byte_stuffer u_stuffer (
    .clk(clk),
    .rst(rst),
    .in_valid(cnt >= CW'(8)),
    .in_byte(acc[ACC_W-1 -: 8]),
    .in_ready(s_in_ready),
    .out_valid(s_out_valid),
    .out_byte(s_out_byte),
    .out_ready(asm_ready)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      acc <= '0;
      cnt <= '0;
      lo <= 8'h00;
      lo_valid <= 1'b0;
      word_pending <= 1'b0;
      bp.out_bits <= 16'h0000;
      bp.out_valid <= 2'b00;
      bp.done_flush <= 1'b0;
    end else begin
      acc <= accept ? acc_sh | code_ext : acc_sh;
      cnt <= accept ? cnt_sh + CW'(bp.in_len) : cnt_sh;
      bp.done_flush <= 1'b0;
      if (bp.ena_out) begin
        word_pending <= 1'b0;
        bp.out_valid <= 2'b00;
      end
      if (asm_take && lo_valid) begin
        bp.out_bits <= {s_out_byte, lo};
        bp.out_valid <= 2'b11;
        word_pending <= 1'b1;
        lo_valid <= 1'b0;
      end else if (asm_take) begin
        lo <= s_out_byte;
        lo_valid <= 1'b1;
      end
      case (state)
        RUN: if (bp.flush && !bp.in_valid) state <= PAD;
        PAD: if (cnt < CW'(8)) begin
          // Top up the partial byte with pad bits so it can be extracted normally
          if (cnt != '0) begin
            acc <= acc | {({8{JPEG_PAD_BIT}} >> cnt), {(ACC_W-8){1'b0}}};
            cnt <= CW'(8);
          end
          state <= DRAIN;
        end
        DRAIN: if (cnt == '0 && !s_out_valid && !word_pending) begin
          if (lo_valid) begin
            bp.out_bits <= {8'h00, lo};
            bp.out_valid <= 2'b01;
            word_pending <= 1'b1;
            lo_valid <= 1'b0;
            state <= LAST;
          end else begin
            bp.done_flush <= 1'b1;
            state <= DONE;
          end
        end
        LAST: if (bp.ena_out) begin
          bp.done_flush <= 1'b1;
          state <= DONE;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
